// File: rtl/apb_gpio_irq_pkg.sv
// rtl/apb_gpio_irq_pkg.sv - register map and bus widths for the APB GPIO block
// Contents: ADDR_W/APB_DW bus widths and the gpio_reg_e word-index enum
// shared by the bus interface, the register file and the testbench.
package apb_gpio_irq_pkg;

   localparam int ADDR_W = 5;
   localparam int APB_DW = 32;

   // Word index taken from PADDR[4:2]
   typedef enum logic [2:0] {
      GPIO_MODER = 3'd0,
      GPIO_IDR   = 3'd1,
      GPIO_ODR   = 3'd2,
      GPIO_OSET  = 3'd3,
      GPIO_OCLR  = 3'd4,
      GPIO_IER   = 3'd5,
      GPIO_ITRIG = 3'd6,
      GPIO_ISR   = 3'd7
   } gpio_reg_e;

endpackage

// File: rtl/apb_gpio_irq_if.sv
// rtl/apb_gpio_irq_if.sv - APB3 slave bus bundle for the GPIO block
// Signals: PADDR, PWDATA, PWRITE, PENABLE, PSEL (master -> slave),
//          PRDATA, PREADY (slave -> master).
// Modports: master (bus driver), slave (peripheral).
interface apb_gpio_irq_if;
   import apb_gpio_irq_pkg::*;

   logic [ADDR_W-1:0] PADDR;
   logic [APB_DW-1:0] PWDATA;
   logic              PWRITE;
   logic              PENABLE;
   logic              PSEL;
   logic [APB_DW-1:0] PRDATA;
   logic              PREADY;

   modport master (
      output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
      output PRDATA, PREADY
   );

endinterface

// File: rtl/apb_gpio_irq_edge_detect.sv
// rtl/apb_gpio_irq_edge_detect.sv - pad synchronizer, edge detector and warm-up gate
// Ports: PCLK, PRESET (async, active-high) ; async_in raw pad values ;
//        mode (1=output pin) ; trig (1=rising, 0=falling) ;
//        sync_out synchronized pad value ; ev per-pin qualified edge event.
module apb_gpio_irq_edge_detect #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic [WIDTH-1:0] async_in,
   input  logic [WIDTH-1:0] mode,
   input  logic [WIDTH-1:0] trig,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] ev
);

   localparam int WARM = SYNC_STAGES + 1;
   localparam int CW   = $clog2(WARM + 1);

   logic [WIDTH-1:0] stage [SYNC_STAGES];
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [CW-1:0]    warm_cnt;
   logic             armed;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            stage[k] <= '0;
         end
         prev <= '0;
      end else begin
         stage[0] <= async_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            stage[k] <= stage[k-1];
         end
         prev <= stage[SYNC_STAGES-1];
      end
   end

   // Flops clear to 0, so a pad already high at reset release looks like a
   // rising edge while the synchronizer fills. Events stay blocked until the
   // chain and prev have both seen real pad data; the counter then saturates.
   assign armed = (warm_cnt == CW'(WARM));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         warm_cnt <= '0;
      end else if (!armed) begin
         warm_cnt <= warm_cnt + CW'(1);
      end
   end

   assign sync_out = stage[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev;
   assign fall     = ~sync_out & prev;

   // Output pins are excluded so driving a pin never flags an interrupt.
   assign ev = armed ? (((trig & rise) | (~trig & fall)) & ~mode) : '0;

endmodule

// File: rtl/apb_gpio_irq.sv
// rtl/apb_gpio_irq.sv - APB3 GPIO peripheral with set/clear outputs and edge interrupts
// Ports: PCLK, PRESET (async, active-high) ; apb APB3 slave bundle
//        (registered PRDATA/PREADY, one wait state) ; irq level interrupt
//        |(ISR & IER) ; gpio_io WIDTH bidirectional pads.
module apb_gpio_irq
   import apb_gpio_irq_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   apb_gpio_irq_if.slave        apb,
   output logic                 irq,
   inout  wire  [WIDTH-1:0]     gpio_io
);

   logic [WIDTH-1:0]  moder;
   logic [WIDTH-1:0]  odr;
   logic [WIDTH-1:0]  ier;
   logic [WIDTH-1:0]  itrig;
   logic [WIDTH-1:0]  isr;
   logic [WIDTH-1:0]  idr;
   logic [WIDTH-1:0]  ev;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  w1c;
   logic              access;
   logic              wr;
   gpio_reg_e         idx;
   logic [APB_DW-1:0] rdata;
   logic              unused_bits;

   // Only the first cycle of an access phase does work; the PREADY term
   // stops a master that holds PSEL/PENABLE from triggering a second access
   // on the completion cycle.
   assign access = apb.PSEL & apb.PENABLE & ~apb.PREADY;
   assign wr     = access & apb.PWRITE;
   assign idx    = gpio_reg_e'(apb.PADDR[4:2]);
   assign wdata  = apb.PWDATA[WIDTH-1:0];

   // Byte lane bits and data bits above WIDTH carry no meaning here.
   assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         moder <= '0;
         odr   <= '0;
         ier   <= '0;
         itrig <= '0;
      end else if (wr) begin
         case (idx)
            GPIO_MODER: moder <= wdata;
            GPIO_ODR:   odr   <= wdata;
            GPIO_OSET:  odr   <= odr | wdata;
            GPIO_OCLR:  odr   <= odr & ~wdata;
            GPIO_IER:   ier   <= wdata;
            GPIO_ITRIG: itrig <= wdata;
            default:    ;
         endcase
      end
   end

   // A new event beats a simultaneous write-1-to-clear so no edge is lost.
   assign w1c = (wr && (idx == GPIO_ISR)) ? wdata : '0;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         isr <= '0;
      end else begin
         isr <= (isr & ~w1c) | ev;
      end
   end

   always_comb begin
      rdata = '0;
      case (idx)
         GPIO_MODER: rdata[WIDTH-1:0] = moder;
         GPIO_IDR:   rdata[WIDTH-1:0] = idr;
         GPIO_ODR:   rdata[WIDTH-1:0] = odr;
         GPIO_IER:   rdata[WIDTH-1:0] = ier;
         GPIO_ITRIG: rdata[WIDTH-1:0] = itrig;
         GPIO_ISR:   rdata[WIDTH-1:0] = isr;
         default:    rdata = '0;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         apb.PREADY <= 1'b0;
         apb.PRDATA <= '0;
      end else begin
         apb.PREADY <= access;
         if (access && !apb.PWRITE) begin
            apb.PRDATA <= rdata;
         end
      end
   end

   // mode/trig feed the detector from the flops, so a same-cycle write to
   // MODER/ITRIG only affects events from the following cycle on.
   apb_gpio_irq_edge_detect #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .async_in (gpio_io),
      .mode     (moder),
      .trig     (itrig),
      .sync_out (idr),
      .ev       (ev)
   );

   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign gpio_io[i] = moder[i] ? odr[i] : 1'bz;
   end

   assign irq = |(isr & ier);

endmodule

// File: tb/tb_apb_gpio_irq.sv
// tb/tb_apb_gpio_irq.sv - directed self-checking bench for apb_gpio_irq
module tb_apb_gpio_irq;
   import apb_gpio_irq_pkg::*;

   logic PCLK = 1'b0;
   logic PRESET = 1'b1;
   always #5 PCLK = ~PCLK;

   int checks = 0;
   int errors = 0;

   logic [4:0]  paddr   = '0;
   logic [31:0] pwdata  = '0;
   logic        pwrite  = 1'b0;
   logic        penable = 1'b0;
   logic [2:0]  psel    = '0;

   apb_gpio_irq_if b0();
   apb_gpio_irq_if b1();
   apb_gpio_irq_if b2();

   assign b0.PADDR = paddr; assign b0.PWDATA = pwdata; assign b0.PWRITE = pwrite;
   assign b0.PENABLE = penable; assign b0.PSEL = psel[0];
   assign b1.PADDR = paddr; assign b1.PWDATA = pwdata; assign b1.PWRITE = pwrite;
   assign b1.PENABLE = penable; assign b1.PSEL = psel[1];
   assign b2.PADDR = paddr; assign b2.PWDATA = pwdata; assign b2.PWRITE = pwrite;
   assign b2.PENABLE = penable; assign b2.PSEL = psel[2];

   logic        irq0, irq1, irq2;
   wire  [7:0]  p0;
   wire  [31:0] p1;
   wire  [4:0]  p2;
   logic [7:0]  ext_en0 = '1;
   logic [7:0]  ext_val0 = '0;
   logic [31:0] ext_en1 = '1;
   logic [31:0] ext_val1 = '0;

   for (genvar i = 0; i < 8; i++) begin : g_ext0
      assign p0[i] = ext_en0[i] ? ext_val0[i] : 1'bz;
   end
   for (genvar i = 0; i < 32; i++) begin : g_ext1
      assign p1[i] = ext_en1[i] ? ext_val1[i] : 1'bz;
   end

   apb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) u0 (
      .PCLK(PCLK), .PRESET(PRESET), .apb(b0), .irq(irq0), .gpio_io(p0));
   apb_gpio_irq #(.WIDTH(32), .SYNC_STAGES(3)) u1 (
      .PCLK(PCLK), .PRESET(PRESET), .apb(b1), .irq(irq1), .gpio_io(p1));
   apb_gpio_irq #(.WIDTH(5), .SYNC_STAGES(2)) u2 (
      .PCLK(PCLK), .PRESET(PRESET), .apb(b2), .irq(irq2), .gpio_io(p2));

   function automatic logic cur_ready(input int sel);
      case (sel)
         0:       return b0.PREADY;
         1:       return b1.PREADY;
         default: return b2.PREADY;
      endcase
   endfunction

   function automatic logic [31:0] cur_rdata(input int sel);
      case (sel)
         0:       return b0.PRDATA;
         1:       return b1.PRDATA;
         default: return b2.PRDATA;
      endcase
   endfunction

   // Called and returns at a negedge. Setup, access, then one idle cycle.
   task automatic xfer(input int sel, input logic w, input gpio_reg_e r,
                       input logic [31:0] wd, output logic [31:0] rd);
      int n;
      paddr = {r, 2'b00}; pwdata = wd; pwrite = w; psel = 3'(1 << sel); penable = 1'b0;
      @(negedge PCLK);
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge PCLK);
         n++;
      end while (cur_ready(sel) !== 1'b1 && n < 8);
      checks++;
      if (cur_ready(sel) !== 1'b1) begin
         errors++;
         $display("FAIL pready_timeout sel=%0d reg=%0d got=%b want=1", sel, r, cur_ready(sel));
      end
      rd = cur_rdata(sel);
      psel = '0; penable = 1'b0;
      @(negedge PCLK);
      checks++;
      if (cur_ready(sel) !== 1'b0) begin
         errors++;
         $display("FAIL pready_pulse sel=%0d reg=%0d got=%b want=0", sel, r, cur_ready(sel));
      end
   endtask

   task automatic wr(input int sel, input gpio_reg_e r, input logic [31:0] d);
      logic [31:0] dummy;
      xfer(sel, 1'b1, r, d, dummy);
   endtask

   task automatic rd(input int sel, input gpio_reg_e r, output logic [31:0] d);
      xfer(sel, 1'b0, r, 32'h0, d);
   endtask

   task automatic test_reset;
      logic [31:0] v;
      PRESET = 1'b1;
      repeat (3) @(negedge PCLK);
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (cur_ready(s) !== 1'b0 || cur_rdata(s) !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus sel=%0d pready=%b prdata=%h want 0/00000000", s, cur_ready(s), cur_rdata(s));
         end
      end
      checks++;
      if ({irq0, irq1, irq2} !== 3'b000) begin
         errors++;
         $display("FAIL reset_irq got=%b want=000", {irq0, irq1, irq2});
      end
      PRESET = 1'b0;
      for (int k = 0; k < 8; k++) begin
         rd(0, gpio_reg_e'(k), v);
         checks++;
         if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_read word=%0d got=%h want=00000000", k, v);
         end
      end
      checks++;
      if (irq0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq_after got=%b want=0", irq0);
      end
      // pads released: external pattern must come through untouched
      ext_val0 = 8'h5A;
      repeat (3) @(negedge PCLK);
      rd(0, GPIO_IDR, v);
      checks++;
      if (v !== 32'h5A) begin
         errors++;
         $display("FAIL reset_pads_released got=%h want=0000005a", v);
      end
      ext_val0 = 8'h00;
   endtask

   task automatic test_output;
      logic [31:0] v;
      ext_en0 = 8'h00;
      wr(0, GPIO_MODER, 32'hFF);
      wr(0, GPIO_ODR, 32'hA5);
      checks++;
      if (p0 !== 8'hA5) begin errors++; $display("FAIL out_odr got=%h want=a5", p0); end
      wr(0, GPIO_OSET, 32'h0A);
      checks++;
      if (p0 !== 8'hAF) begin errors++; $display("FAIL out_oset got=%h want=af", p0); end
      wr(0, GPIO_OCLR, 32'h81);
      checks++;
      if (p0 !== 8'h2E) begin errors++; $display("FAIL out_oclr got=%h want=2e", p0); end
      rd(0, GPIO_ODR, v);
      checks++;
      if (v !== 32'h2E) begin errors++; $display("FAIL out_odr_read got=%h want=0000002e", v); end
      rd(0, GPIO_OSET, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL out_oset_read got=%h want=00000000", v); end
      rd(0, GPIO_OCLR, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL out_oclr_read got=%h want=00000000", v); end
      rd(0, GPIO_IDR, v);
      checks++;
      if (v !== 32'h2E) begin errors++; $display("FAIL out_idr_read got=%h want=0000002e", v); end
      wr(0, GPIO_MODER, 32'h00);
      ext_val0 = 8'h00;
      ext_en0 = 8'hFF;
   endtask

   task automatic test_idr;
      logic [31:0] v;
      repeat (3) @(negedge PCLK);
      ext_val0 = 8'h3C;
      rd(0, GPIO_IDR, v);
      checks++;
      if (v !== 32'h00) begin errors++; $display("FAIL idr_early got=%h want=00000000", v); end
      rd(0, GPIO_IDR, v);
      checks++;
      if (v !== 32'h3C) begin errors++; $display("FAIL idr_settled got=%h want=0000003c", v); end
      ext_val0 = 8'hC3;
      repeat (2) @(negedge PCLK);
      rd(0, GPIO_IDR, v);
      checks++;
      if (v !== 32'hC3) begin errors++; $display("FAIL idr_latency got=%h want=000000c3", v); end
   endtask

   task automatic test_irq;
      logic [31:0] v;
      ext_val0 = 8'h00;
      repeat (4) @(negedge PCLK);
      wr(0, GPIO_ITRIG, 32'h01);
      wr(0, GPIO_IER, 32'h01);
      wr(0, GPIO_ISR, 32'hFF);
      rd(0, GPIO_ISR, v);
      checks++;
      if (v !== 32'h0 || irq0 !== 1'b0) begin
         errors++; $display("FAIL irq_clear_all isr=%h irq=%b want 00000000/0", v, irq0);
      end
      ext_val0 = 8'h01;
      for (int k = 1; k <= 3; k++) begin
         @(negedge PCLK);
         if (k == 2) begin
            checks++;
            if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_too_early got=%b want=0", irq0); end
         end
         if (k == 3) begin
            checks++;
            if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_latency got=%b want=1", irq0); end
         end
      end
      rd(0, GPIO_ISR, v);
      checks++;
      if (v !== 32'h01) begin errors++; $display("FAIL irq_isr_rise got=%h want=00000001", v); end
      wr(0, GPIO_ISR, 32'h01);
      checks++;
      if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_w1c got=%b want=0", irq0); end
      ext_val0 = 8'h00;
      repeat (5) @(negedge PCLK);
      rd(0, GPIO_ISR, v);
      checks++;
      if (v !== 32'h0 || irq0 !== 1'b0) begin
         errors++; $display("FAIL irq_fall_ignored isr=%h irq=%b want 00000000/0", v, irq0);
      end
      // pin1 is falling-edge and not enabled: pending set, irq masked
      ext_val0 = 8'h02;
      repeat (4) @(negedge PCLK);
      ext_val0 = 8'h00;
      repeat (4) @(negedge PCLK);
      rd(0, GPIO_ISR, v);
      checks++;
      if (v !== 32'h02 || irq0 !== 1'b0) begin
         errors++; $display("FAIL irq_masked isr=%h irq=%b want 00000002/0", v, irq0);
      end
      wr(0, GPIO_ISR, 32'hFF);
      // pin2 as output toggling must not flag
      ext_en0 = 8'hFB;
      wr(0, GPIO_ODR, 32'h04);
      wr(0, GPIO_MODER, 32'h04);
      wr(0, GPIO_ODR, 32'h00);
      repeat (4) @(negedge PCLK);
      rd(0, GPIO_ISR, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL irq_output_gated got=%h want=00000000", v); end
      wr(0, GPIO_MODER, 32'h00);
      ext_en0 = 8'hFF;
      ext_val0 = 8'h00;
   endtask

   task automatic test_simul;
      logic [31:0] v;
      repeat (3) @(negedge PCLK);
      ext_val0 = 8'h01;
      @(negedge PCLK);
      // access edge of this W1C is the edge the rise event lands on
      wr(0, GPIO_ISR, 32'h01);
      rd(0, GPIO_ISR, v);
      checks++;
      if (v !== 32'h01 || irq0 !== 1'b1) begin
         errors++; $display("FAIL simul_set_wins isr=%h irq=%b want 00000001/1", v, irq0);
      end
      wr(0, GPIO_ISR, 32'h01);
      ext_val0 = 8'h00;
      repeat (4) @(negedge PCLK);
   endtask

   task automatic test_back_to_back;
      logic [5:0] seq;
      logic [31:0] v;
      paddr = {GPIO_ITRIG, 2'b00}; pwrite = 1'b0; pwdata = '0; psel = 3'b001; penable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge PCLK);
         seq[5-k] = b0.PREADY;
      end
      psel = '0; penable = 1'b0;
      @(negedge PCLK);
      checks++;
      if (seq !== 6'b101010) begin errors++; $display("FAIL b2b_pready got=%b want=101010", seq); end
      checks++;
      if (b0.PRDATA !== 32'h01) begin errors++; $display("FAIL b2b_prdata got=%h want=00000001", b0.PRDATA); end
      wr(0, GPIO_IER, 32'h00);
      checks++;
      if (b0.PRDATA !== 32'h01) begin errors++; $display("FAIL prdata_hold got=%h want=00000001", b0.PRDATA); end
      rd(0, GPIO_IER, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL b2b_ier got=%h want=00000000", v); end
   endtask

   task automatic test_wide;
      logic [31:0] v;
      wr(1, GPIO_OSET, 32'h8000_0001);
      rd(1, GPIO_ODR, v);
      checks++;
      if (v !== 32'h8000_0001) begin errors++; $display("FAIL wide_oset got=%h want=80000001", v); end
      rd(1, GPIO_OSET, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL wide_oset_read got=%h want=00000000", v); end
      wr(1, GPIO_ITRIG, 32'h8000_0000);
      wr(1, GPIO_IER, 32'h8000_0000);
      wr(1, GPIO_ISR, 32'hFFFF_FFFF);
      ext_val1 = 32'h8000_0000;
      for (int k = 1; k <= 4; k++) begin
         @(negedge PCLK);
         if (k == 3) begin
            checks++;
            if (irq1 !== 1'b0) begin errors++; $display("FAIL wide_irq_early got=%b want=0", irq1); end
         end
         if (k == 4) begin
            checks++;
            if (irq1 !== 1'b1) begin errors++; $display("FAIL wide_irq_latency got=%b want=1", irq1); end
         end
      end
      rd(1, GPIO_ISR, v);
      checks++;
      if (v !== 32'h8000_0000) begin errors++; $display("FAIL wide_isr got=%h want=80000000", v); end
   endtask

   task automatic test_narrow;
      logic [31:0] v;
      wr(2, GPIO_MODER, 32'hFFFF_FFFF);
      rd(2, GPIO_MODER, v);
      checks++;
      if (v !== 32'h1F) begin errors++; $display("FAIL narrow_moder got=%h want=0000001f", v); end
      wr(2, GPIO_ODR, 32'hFFFF_FFFF);
      rd(2, GPIO_ODR, v);
      checks++;
      if (v !== 32'h1F) begin errors++; $display("FAIL narrow_odr got=%h want=0000001f", v); end
      rd(2, GPIO_IDR, v);
      checks++;
      if (v !== 32'h1F) begin errors++; $display("FAIL narrow_idr got=%h want=0000001f", v); end
   endtask

   task automatic test_warmup;
      logic [31:0] v;
      // reset lands while a completion is on the bus
      paddr = {GPIO_IER, 2'b00}; pwdata = 32'hFF; pwrite = 1'b1; psel = 3'b001; penable = 1'b0;
      @(negedge PCLK);
      penable = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b1;
      #1;
      checks++;
      if (b0.PREADY !== 1'b0) begin errors++; $display("FAIL reset_mid_xfer pready=%b want=0", b0.PREADY); end
      psel = '0; penable = 1'b0;
      ext_en0 = 8'hFF;
      ext_val0 = 8'h01;
      repeat (2) @(negedge PCLK);
      // ITRIG write commits on the first edge after release
      paddr = {GPIO_ITRIG, 2'b00}; pwdata = 32'h01; pwrite = 1'b1; psel = 3'b001; penable = 1'b1;
      PRESET = 1'b0;
      @(negedge PCLK);
      checks++;
      if (b0.PREADY !== 1'b1) begin errors++; $display("FAIL warm_itrig_ack pready=%b want=1", b0.PREADY); end
      psel = '0; penable = 1'b0;
      repeat (6) @(negedge PCLK);
      rd(0, GPIO_ISR, v);
      checks++;
      if (v !== 32'h0 || irq0 !== 1'b0) begin
         errors++; $display("FAIL warmup_isr isr=%h irq=%b want 00000000/0", v, irq0);
      end
      rd(0, GPIO_ITRIG, v);
      checks++;
      if (v !== 32'h01) begin errors++; $display("FAIL warmup_itrig got=%h want=00000001", v); end
      rd(0, GPIO_IER, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_lost_write got=%h want=00000000", v); end
   endtask

   initial begin
      test_reset;
      test_output;
      test_idr;
      test_irq;
      test_simul;
      test_back_to_back;
      test_wide;
      test_narrow;
      test_warmup;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
